instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the main control decoder: keeps the PC, fetches 32-bit words from instruction memory

---
 rtl/instr_fetch_unit.sv | 104 ++++++++++
 tb/tb_instr_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, req/ack instruction fetch, instruction register and decoded field slices.
// Optional IFU_PERF_CNT_EN adds fetch_count / redirect_count performance counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              jump,
  input  logic [25:0]       jump_index,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       redirect_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              capture, consume;

  assign pc_plus4 = pc + ADDR_W'(4);

  // Moore handshake: req and valid depend only on state, never on inputs
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign pc_out      = pc;

  assign capture = (state == REQ) && imem_ack;
  assign consume = (state == HOLD) && !stall;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = REQ;
      REQ:     if (imem_ack) state_nxt = HOLD;
      HOLD:    if (!stall) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Redirect priority: jump over branch over sequential
  always_comb begin
    pc_nxt = pc_plus4;
    if (jump)
      pc_nxt = {pc_plus4[ADDR_W-1 -: 4], jump_index, 2'b00};
    else if (branch_taken)
      pc_nxt = pc_plus4 + (branch_offset << 2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      state <= state_nxt;
      if (capture) instr <= imem_rdata;
      if (consume) pc <= pc_nxt;
    end
  end

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count    <= 32'h0;
      redirect_count <= 32'h0;
    end else begin
      if (capture) fetch_count <= fetch_count + 32'h1;
      if (consume && (jump || branch_taken)) redirect_count <= redirect_count + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: per-cycle vector table plus hand sequences for wrap and reset.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, imem_ack, stall, jump, branch_taken;
  logic [31:0] imem_rdata, branch_offset;
  logic [25:0] jump_index;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_out, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  logic        w_rst_n, w_ack, w_stall;
  logic [31:0] w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count, redirect_count, w_fc, w_rc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .jump(jump),
    .jump_index(jump_index), .branch_taken(branch_taken), .branch_offset(branch_offset),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm(imm), .pc_out(pc_out), .pc_plus4(pc_plus4)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(fetch_count), .redirect_count(redirect_count)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(w_stall), .jump(1'b0),
    .jump_index(26'h0), .branch_taken(1'b0), .branch_offset(32'h0),
    .instr_valid(w_valid), .instr(w_instr), .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .shamt(w_shamt), .funct(w_funct), .imm(w_imm), .pc_out(w_pc), .pc_plus4(w_pc4)
`ifdef IFU_PERF_CNT_EN
    , .fetch_count(w_fc), .redirect_count(w_rc)
`endif
  );

  typedef struct {
    logic        stall, jump, br, ack;
    logic [25:0] jidx;
    logic [31:0] boff, rdata;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_instr;
  } vec_t;

  localparam logic [31:0] LW  = 32'h8C41_0004;
  localparam logic [31:0] SLL = 32'h0003_1080;
  localparam logic [31:0] BEQ = 32'h1000_FFFE;
  localparam logic [31:0] ADD = 32'h012A_4020;
  localparam logic [31:0] JMP = 32'h0800_0040;

  vec_t vecs[24];

  function automatic vec_t v(logic st, logic j, logic [25:0] ji, logic b, logic [31:0] bo,
                             logic a, logic [31:0] rdat, logic er, logic [31:0] ea,
                             logic ev, logic [31:0] ei);
    vec_t r;
    r.stall = st; r.jump = j; r.jidx = ji; r.br = b; r.boff = bo; r.ack = a; r.rdata = rdat;
    r.e_req = er; r.e_addr = ea; r.e_valid = ev; r.e_instr = ei;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [5:0] op, input logic [4:0] s,
                            input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] im);
    chk({tag, ".opcode"}, 32'(opcode), 32'(op));
    chk({tag, ".rs"},     32'(rs),     32'(s));
    chk({tag, ".rt"},     32'(rt),     32'(t));
    chk({tag, ".rd"},     32'(rd),     32'(d));
    chk({tag, ".shamt"},  32'(shamt),  32'(sh));
    chk({tag, ".funct"},  32'(funct),  32'(fn));
    chk({tag, ".imm"},    32'(imm),    32'(im));
  endtask

  initial begin
    //            st j  jidx        br boff          ack rdata          req addr          vld instr
    vecs[0]  = v(0, 0, 26'h0,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0, 32'h0);
    vecs[1]  = v(0, 0, 26'h0,      0, 32'h0,        1, 32'h20,       1, 32'h0000_0000, 0, 32'h0);
    vecs[2]  = v(0, 0, 26'h0,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 1, 32'h20);
    vecs[3]  = v(0, 0, 26'h0,      0, 32'h0,        1, 32'h20,       1, 32'h0000_0004, 0, 32'h20);
    vecs[4]  = v(0, 0, 26'h0,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0004, 1, 32'h20);
    vecs[5]  = v(1, 0, 26'h0,      0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 32'h20);
    vecs[6]  = v(0, 0, 26'h0,      0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 32'h20);
    vecs[7]  = v(0, 0, 26'h0,      0, 32'h0,        0, 32'h0,        1, 32'h0000_0008, 0, 32'h20);
    vecs[8]  = v(0, 0, 26'h0,      0, 32'h0,        1, LW,           1, 32'h0000_0008, 0, 32'h20);
    vecs[9]  = v(1, 0, 26'h0,      0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h0000_0008, 1, LW);
    vecs[10] = v(1, 1, 26'h3FF,    0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h0000_0008, 1, LW);
    vecs[11] = v(1, 0, 26'h0,      1, 32'h10,       0, 32'h0,        0, 32'h0000_0008, 1, LW);
    vecs[12] = v(1, 0, 26'h0,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0008, 1, LW);
    vecs[13] = v(1, 0, 26'h0,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0008, 1, LW);
    vecs[14] = v(0, 0, 26'h0,      0, 32'h0,        0, 32'h0,        0, 32'h0000_0008, 1, LW);
    vecs[15] = v(0, 0, 26'h0,      0, 32'h0,        1, SLL,          1, 32'h0000_000C, 0, LW);
    vecs[16] = v(0, 1, 26'h40,     0, 32'h0,        0, 32'h0,        0, 32'h0000_000C, 1, SLL);
    vecs[17] = v(0, 0, 26'h0,      0, 32'h0,        1, BEQ,          1, 32'h0000_0100, 0, SLL);
    vecs[18] = v(0, 0, 26'h0,      1, 32'hFFFF_FFFE, 0, 32'h0,       0, 32'h0000_0100, 1, BEQ);
    vecs[19] = v(1, 1, 26'h3FFFFFF, 1, 32'h40,      1, ADD,          1, 32'h0000_00FC, 0, BEQ);
    vecs[20] = v(0, 0, 26'h0,      0, 32'h0,        0, 32'h0,        0, 32'h0000_00FC, 1, ADD);
    vecs[21] = v(0, 0, 26'h0,      0, 32'h0,        1, JMP,          1, 32'h0000_0100, 0, ADD);
    vecs[22] = v(0, 1, 26'h40,     1, 32'hFFFF_FFFE, 1, 32'h1234_5678, 0, 32'h0000_0100, 1, JMP);
    vecs[23] = v(0, 0, 26'h0,      0, 32'h0,        0, 32'h0,        1, 32'h0000_0100, 0, JMP);

    rst_n = 0; imem_ack = 0; imem_rdata = 0; stall = 0; jump = 0; jump_index = 0;
    branch_taken = 0; branch_offset = 0;
    w_rst_n = 0; w_ack = 0; w_rdata = 0; w_stall = 0;
    repeat (3) @(negedge clk);
    chk("reset.instr", instr, 32'h0);
    chk_fields("reset", 6'h0, 5'h0, 5'h0, 5'h0, 5'h0, 6'h0, 16'h0);
    rst_n = 1;

    for (int i = 0; i < 24; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("v%0d.req", i),   32'(imem_req),    32'(vecs[i].e_req));
      chk($sformatf("v%0d.addr", i),  imem_addr,        vecs[i].e_addr);
      chk($sformatf("v%0d.valid", i), 32'(instr_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d.instr", i), instr,            vecs[i].e_instr);
      chk($sformatf("v%0d.pc", i),    pc_out,           vecs[i].e_addr);
      chk($sformatf("v%0d.pc4", i),   pc_plus4,         vecs[i].e_addr + 32'd4);
      if (i == 2)  chk_fields("v2",  6'h00, 5'd0, 5'd0,  5'd0, 5'd0, 6'h20, 16'h0020);
      if (i == 9)  chk_fields("v9",  6'h23, 5'd2, 5'd1,  5'd0, 5'd0, 6'h04, 16'h0004);
      if (i == 16) chk_fields("v16", 6'h00, 5'd0, 5'd3,  5'd2, 5'd2, 6'h00, 16'h1080);
      if (i == 20) chk_fields("v20", 6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020);
      stall = vecs[i].stall; jump = vecs[i].jump; jump_index = vecs[i].jidx;
      branch_taken = vecs[i].br; branch_offset = vecs[i].boff;
      imem_ack = vecs[i].ack; imem_rdata = vecs[i].rdata;
    end

`ifdef IFU_PERF_CNT_EN
    chk("perf.fetch", fetch_count, 32'd7);
    chk("perf.redir", redirect_count, 32'd3);
`endif

    // Reset mid-request: req drops without a clock edge, late ack ignored
    @(negedge clk);
    chk("rst.pre_req", 32'(imem_req), 32'd1);
    imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
    rst_n = 0;
    #1;
    chk("rst.req_drop", 32'(imem_req), 32'd0);
    chk("rst.instr0", instr, 32'h0);
    chk("rst.pc0", pc_out, 32'h0);
    @(negedge clk);
    rst_n = 1;
    chk("rst.idle_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("rst.refetch_req", 32'(imem_req), 32'd1);
    chk("rst.refetch_addr", imem_addr, 32'h0);
    chk("rst.late_ack_ignored", instr, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("rst.perf_fetch", fetch_count, 32'd0);
    chk("rst.perf_redir", redirect_count, 32'd0);
`endif
    imem_ack = 0;

    // PC wrap at top of address space
    @(negedge clk);
    w_rst_n = 1;
    chk("wrap.idle_addr", w_addr, 32'hFFFF_FFFC);
    chk("wrap.idle_req", 32'(w_req), 32'd0);
    @(negedge clk);
    chk("wrap.req", 32'(w_req), 32'd1);
    w_ack = 1; w_rdata = 32'h20;
    @(negedge clk);
    chk("wrap.valid", 32'(w_valid), 32'd1);
    chk("wrap.pc4", w_pc4, 32'h0);
    w_ack = 0; w_stall = 0;
    @(negedge clk);
    chk("wrap.next_req", 32'(w_req), 32'd1);
    chk("wrap.next_addr", w_addr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
